// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a valid/ready word FIFO feeding a start/data/parity/stop
// serialiser timed by an external N_TICKS-per-bit tick enable.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line high; pops the next word as soon as the FIFO holds one
// S_START  | start bit (line low) for N_TICKS ticks
// S_DATA   | data bits, LSB first, N_TICKS ticks each
// S_PARITY | parity bit (even/odd) for N_TICKS ticks, skipped if none
// S_STOP   | stop level for NB_STOP*N_TICKS ticks; chains the next word
module uart_tx_fifo #(
  parameter int NB_DATA     = 8,
  parameter int NB_STOP     = 1,
  parameter int PARITY_MODE = 0,
  parameter int FIFO_DEPTH  = 4,
  parameter int N_TICKS     = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_tick,
  input  logic [NB_DATA-1:0]            i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_data,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int STOP_TICKS = NB_STOP * N_TICKS;
  localparam int TICK_W     = (STOP_TICKS > 1) ? $clog2(STOP_TICKS) : 1;
  localparam int BIT_W      = $clog2(NB_DATA);
  localparam bit HAS_PARITY = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam bit ODD_PARITY = (PARITY_MODE == 2);

  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [TICK_W-1:0] BIT_LIM  = TICK_W'(N_TICKS - 1);
  localparam logic [TICK_W-1:0] STOP_LIM = TICK_W'(STOP_TICKS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(NB_DATA - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [NB_DATA-1:0]  shift_q, shift_d;
  logic                parity_q, parity_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                data_q, data_d;
  logic                done_q, done_d;

  logic [NB_DATA-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;

  logic                push, pop;
  logic                fifo_nempty;
  logic [NB_DATA-1:0]  fifo_word;
  logic                word_parity;
  logic [TICK_W-1:0]   tick_lim;
  logic                period_end;

  // Acceptance depends on the registered count only, so a pop never frees a slot early.
  assign o_ready     = (count_q < DEPTH_C);
  assign push        = i_valid && o_ready;
  assign fifo_nempty = (count_q != '0);
  assign fifo_word   = mem[rd_ptr_q];
  assign word_parity = (^fifo_word) ^ ODD_PARITY;

  assign o_data  = data_q;
  assign o_done  = done_q;
  assign o_busy  = (state_q != S_IDLE);
  assign o_count = count_q;

  always_ff @(posedge i_clock) begin
    if (push) begin
      mem[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      data_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    tick_cnt_d = tick_cnt_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    data_d     = 1'b1;

    tick_lim   = (state_q == S_STOP) ? STOP_LIM : BIT_LIM;
    period_end = i_tick && (tick_cnt_q == tick_lim);

    if (i_tick) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
    if (period_end) begin
      tick_cnt_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        tick_cnt_d = '0;
        if (fifo_nempty) begin
          pop      = 1'b1;
          shift_d  = fifo_word;
          parity_d = word_parity;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (period_end) begin
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (period_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = HAS_PARITY ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (period_end) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (period_end) begin
          done_d = 1'b1;
          if (fifo_nempty) begin
            pop      = 1'b1;
            shift_d  = fifo_word;
            parity_d = word_parity;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Line level is taken from the next state so it moves on the same edge as the FSM.
    case (state_d)
      S_START:  data_d = 1'b0;
      S_DATA:   data_d = shift_d[0];
      S_PARITY: data_d = parity_d;
      default:  data_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame vectors on four parameter sets, hand sequences for
// stall/back-to-back/reset corners, then random traffic against a frame-level model.
module tb_uart_tx_fifo;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_tick;
  logic [7:0] tb_data;
  logic [3:0] valid_w;
  logic [3:0] ready_w, line_w, busy_w, done_w;
  logic [2:0] count_w [4];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tdiv     = 1;

  always #5 i_clock = ~i_clock;

  uart_tx_fifo u_8n1 (
    .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick), .i_data(tb_data),
    .i_valid(valid_w[0]), .o_ready(ready_w[0]), .o_data(line_w[0]),
    .o_busy(busy_w[0]), .o_done(done_w[0]), .o_count(count_w[0]));

  uart_tx_fifo #(.NB_STOP(2), .PARITY_MODE(1)) u_8e2 (
    .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick), .i_data(tb_data),
    .i_valid(valid_w[1]), .o_ready(ready_w[1]), .o_data(line_w[1]),
    .o_busy(busy_w[1]), .o_done(done_w[1]), .o_count(count_w[1]));

  uart_tx_fifo #(.PARITY_MODE(2)) u_8o1 (
    .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick), .i_data(tb_data),
    .i_valid(valid_w[2]), .o_ready(ready_w[2]), .o_data(line_w[2]),
    .o_busy(busy_w[2]), .o_done(done_w[2]), .o_count(count_w[2]));

  uart_tx_fifo #(.NB_DATA(5)) u_5n1 (
    .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick), .i_data(tb_data[4:0]),
    .i_valid(valid_w[3]), .o_ready(ready_w[3]), .o_data(line_w[3]),
    .o_busy(busy_w[3]), .o_done(done_w[3]), .o_count(count_w[3]));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
    cyc++;
  endtask

  task automatic set_tick();
    i_tick = (tdiv > 0) && ((cyc % tdiv) == 0);
  endtask

  task automatic tick_step(output logic t);
    set_tick();
    t = i_tick;
    step();
  endtask

  task automatic reset_all();
    i_reset = 1'b1;
    valid_w = '0;
    set_tick();
    step();
    i_reset = 1'b0;
  endtask

  task automatic write1(input int k, input logic [7:0] d);
    tb_data    = d;
    valid_w[k] = 1'b1;
    set_tick();
    step();
    valid_w[k] = 1'b0;
  endtask

  // Frame-level reference: a word queue plus a tick position inside the current frame.
  logic [7:0] mq [$];
  bit         m_active, m_done;
  int         m_elapsed, m_nb, m_ns, m_par, m_len;
  logic [7:0] m_word;

  function automatic logic m_line();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_elapsed / 16;
    if (idx == 0) return 1'b0;
    if (idx <= m_nb) return m_word[idx-1];
    if (m_par != 0 && idx == m_nb + 1) return (m_par == 2) ? ~^m_word : ^m_word;
    return 1'b1;
  endfunction

  task automatic model_edge(input logic v, input logic [7:0] d, input logic t, input logic r);
    bit push, fend, pop;
    logic [7:0] mask;
    if (r) begin
      mq.delete();
      m_active  = 0;
      m_done    = 0;
      m_elapsed = 0;
      return;
    end
    mask = 8'((1 << m_nb) - 1);
    push = v && (mq.size() < 4);
    fend = m_active && t && (m_elapsed == m_len - 1);
    pop  = (mq.size() > 0) && (!m_active || fend);
    m_done = fend;
    if (pop) begin
      m_word    = mq.pop_front();
      m_active  = 1;
      m_elapsed = 0;
    end else if (fend) begin
      m_active = 0;
    end else if (m_active && t) begin
      m_elapsed++;
    end
    if (push) mq.push_back(d & mask);
  endtask

  task automatic run_random(input int k, input int nb, input int ns, input int par,
                            input int tick_pct, input int ncyc);
    logic v, t, r;
    logic [7:0] d, act, exp;
    m_nb  = nb;
    m_ns  = ns;
    m_par = par;
    m_len = (1 + nb + ((par != 0) ? 1 : 0) + ns) * 16;
    i_reset = 1'b1;
    valid_w = '0;
    i_tick  = 1'b0;
    model_edge(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    for (int c = 0; c < ncyc; c++) begin
      v = ($urandom_range(0, 99) < 6);
      d = 8'($urandom);
      t = ($urandom_range(0, 99) < tick_pct);
      r = ($urandom_range(0, 1999) == 0);
      tb_data    = d;
      valid_w[k] = v;
      i_tick     = t;
      i_reset    = r;
      model_edge(v, d, t, r);
      step();
      act = {ready_w[k], line_w[k], busy_w[k], done_w[k], 1'b0, count_w[k]};
      exp = {(mq.size() < 4), m_line(), m_active, m_done, 1'b0, 3'(mq.size())};
      check($sformatf("random_k%0d_c%0d", k, c), int'(act), int'(exp));
    end
    valid_w = '0;
    i_reset = 1'b0;
  endtask

  typedef struct {
    int          inst;
    logic [7:0]  word;
    logic [11:0] bits;
    int          nbits;
    int          div;
  } frame_vec_t;

  frame_vec_t vecs [6];

  initial begin
    logic t;
    int   done_cnt, gap, found;

    vecs[0] = '{inst:0, word:8'hA5, bits:{2'b00, 1'b1, 8'hA5, 1'b0}, nbits:10, div:1};
    vecs[1] = '{inst:0, word:8'h3C, bits:{2'b00, 1'b1, 8'h3C, 1'b0}, nbits:10, div:1};
    vecs[2] = '{inst:1, word:8'hA5, bits:{2'b11, 1'b0, 8'hA5, 1'b0}, nbits:12, div:1};
    vecs[3] = '{inst:1, word:8'h01, bits:{2'b11, 1'b1, 8'h01, 1'b0}, nbits:12, div:1};
    vecs[4] = '{inst:2, word:8'hA5, bits:{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, nbits:11, div:1};
    vecs[5] = '{inst:3, word:8'h1F, bits:{5'b00000, 1'b1, 5'h1F, 1'b0}, nbits:7, div:4};

    i_reset = 1'b1;
    i_tick  = 1'b1;
    valid_w = '0;
    tb_data = '0;
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_state_k%0d", k),
            int'({ready_w[k], line_w[k], busy_w[k], done_w[k], count_w[k]}), int'(7'b1100_000));
    end
    i_reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      int k, ticks, rise_n, done_n, done_ticks, lim;
      bit seen_low;
      k    = vecs[v].inst;
      tdiv = vecs[v].div;
      write1(k, vecs[v].word);
      seen_low = 0;
      for (int w = 0; w < 20 && !seen_low; w++) begin
        if (line_w[k] == 1'b0) seen_low = 1;
        else tick_step(t);
      end
      check($sformatf("vec%0d_start_seen", v), int'(seen_low), 1);
      ticks = 0; rise_n = -1; done_n = -1; done_ticks = -1; done_cnt = 0;
      lim = vecs[v].nbits * 16 * vecs[v].div + 40;
      for (int n2 = 1; n2 <= lim; n2++) begin
        tick_step(t);
        if (t) begin
          ticks++;
          if ((ticks % 16) == 8 && (ticks / 16) < vecs[v].nbits)
            check($sformatf("vec%0d_bit%0d", v, ticks / 16), int'(line_w[k]),
                  int'(vecs[v].bits[ticks / 16]));
        end
        if (rise_n < 0 && line_w[k]) rise_n = n2;
        if (done_w[k]) begin
          done_cnt++;
          if (done_n < 0) begin
            done_n     = n2;
            done_ticks = ticks;
          end
        end
      end
      check($sformatf("vec%0d_done_pulses", v), done_cnt, 1);
      check($sformatf("vec%0d_frame_ticks", v), done_ticks, vecs[v].nbits * 16);
      if (vecs[v].div == 1)
        check($sformatf("vec%0d_done_latency", v), done_n, vecs[v].nbits * 16);
      if (vecs[v].bits[1])
        check($sformatf("vec%0d_rise_to_done", v), done_n - rise_n,
              (vecs[v].nbits - 1) * 16 * vecs[v].div);
      check($sformatf("vec%0d_idle_after", v), int'(busy_w[k]), 0);
    end

    // Stall with one frame in flight, then overfill the FIFO.
    tdiv = 1;
    reset_all();
    write1(0, 8'h11);
    tick_step(t);
    tdiv = 0;
    check("stall_busy", int'(busy_w[0]), 1);
    for (int i = 0; i < 5; i++) begin
      tb_data    = 8'(8'h20 + i);
      valid_w[0] = 1'b1;
      set_tick();
      step();
      check($sformatf("burst_count_%0d", i), int'(count_w[0]), (i < 4) ? i + 1 : 4);
      check($sformatf("burst_ready_%0d", i), int'(ready_w[0]), (i < 3) ? 1 : 0);
    end
    valid_w = '0;
    tdiv = 1;
    done_cnt = 0;
    gap = 0;
    for (int n2 = 0; n2 < 5 * 160 + 60; n2++) begin
      tick_step(t);
      if (!busy_w[0] && !done_w[0] && done_cnt < 5) gap = 1;
      if (done_w[0]) begin
        done_cnt++;
        if (done_cnt < 5)
          check($sformatf("chain_done%0d_line_busy", done_cnt),
                int'({line_w[0], busy_w[0]}), int'(2'b01));
        else
          check("chain_last_line_busy", int'({line_w[0], busy_w[0]}), int'(2'b10));
      end
    end
    check("chain_done_pulses", done_cnt, 5);
    check("chain_no_idle_gap", gap, 0);
    check("chain_count_empty", int'(count_w[0]), 0);

    // Write during a frame, then check the chained start lines up with o_done.
    reset_all();
    write1(0, 8'h81);
    tick_step(t);
    check("midframe_busy_empty", int'({busy_w[0], count_w[0]}), int'(4'b1_000));
    repeat (10) tick_step(t);
    write1(0, 8'h42);
    check("midframe_count_1", int'(count_w[0]), 1);
    found = 0;
    for (int n2 = 0; n2 < 400 && found < 2; n2++) begin
      tick_step(t);
      if (done_w[0]) begin
        found++;
        if (found == 1)
          check("midframe_done1_state", int'({line_w[0], busy_w[0], count_w[0]}), int'(5'b01_000));
        else
          check("midframe_done2_state", int'({line_w[0], busy_w[0], count_w[0]}), int'(5'b10_000));
      end
    end
    check("midframe_done_seen", found, 2);

    // Reset while bit 3 of 0xA5 (a 0) is on the line, with two words queued.
    reset_all();
    write1(0, 8'hA5);
    tick_step(t);
    write1(0, 8'h01);
    write1(0, 8'h02);
    repeat (68) tick_step(t);
    check("abort_pre_state", int'({line_w[0], busy_w[0], count_w[0]}), int'(5'b01_010));
    i_reset = 1'b1;
    tick_step(t);
    i_reset = 1'b0;
    check("abort_post_state",
          int'({ready_w[0], line_w[0], busy_w[0], done_w[0], count_w[0]}), int'(7'b1100_000));
    done_cnt = 0;
    gap = 0;
    repeat (300) begin
      tick_step(t);
      if (done_w[0]) done_cnt++;
      if (!line_w[0]) gap = 1;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_line_high", gap, 0);

    run_random(0, 8, 1, 0, 100, 2500);
    run_random(1, 8, 2, 1, 50, 2500);
    run_random(2, 8, 1, 2, 100, 2500);
    run_random(3, 5, 1, 0, 30, 2500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
